// File: rtl/pipe_pkg.sv
// Shared pipeline types for the EX->MEM stage.
// Holds the EX/MEM control bundle and its bubble value.
package pipe_pkg;

  typedef struct packed {
    logic mem_to_reg;
    logic mem_read;
    logic mem_write;
    logic reg_write;
  } ex_mem_ctrl_t;

  localparam ex_mem_ctrl_t EX_MEM_CTRL_NOP = '0;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry valid/ready skid buffer, state on falling edge.
// Ports: clk, rst, flush, in_valid/in_ready/in_data,
//        out_valid/out_ready/out_data, skid_valid.
module pipe_skid_buf #(
  parameter type T = logic [31:0],
  // bits kept on flush; cleared bits are forced to 0
  parameter T KEEP_MASK = '1
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data,
  output logic skid_valid
);

  logic slot_v;
  logic skid_v;
  T     slot_q;
  T     skid_q;
  logic acc;
  logic drn;

  // ready comes straight from a flop: no comb path from out_ready
  assign in_ready   = !skid_v;
  assign acc        = in_valid & in_ready;
  assign drn        = slot_v & out_ready;
  assign out_valid  = slot_v;
  assign out_data   = slot_q;
  assign skid_valid = skid_v;

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      slot_v <= 1'b0;
      skid_v <= 1'b0;
      slot_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      slot_v <= 1'b0;
      skid_v <= 1'b0;
      slot_q <= T'(slot_q & KEEP_MASK);
      skid_q <= T'(skid_q & KEEP_MASK);
    end else if (!slot_v || drn) begin
      if (skid_v) begin
        slot_q <= skid_q;
        slot_v <= 1'b1;
        skid_v <= 1'b0;
      end else if (acc) begin
        slot_q <= in_data;
        slot_v <= 1'b1;
      end else begin
        slot_v <= 1'b0;
      end
    end else if (acc) begin
      skid_q <= in_data;
      skid_v <= 1'b1;
    end
  end

  a_skid_implies_slot :
    assert property (@(negedge clk) disable iff (rst)
      skid_v |-> slot_v);

endmodule

// File: rtl/ex_mem_stage_hs.sv
// EX->MEM pipeline stage with valid/ready skid, flush, ctrl masking.
// Optional forwarding tap under macro EX_MEM_FWD_EN.
module ex_mem_stage_hs
  import pipe_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  ex_mem_ctrl_t          in_ctrl,
  input  logic [DATA_W-1:0]     in_alu,
  input  logic [DATA_W-1:0]     in_rd3,
  input  logic [REG_ADDR_W-1:0] in_rr3,
  output logic                  out_valid,
  input  logic                  out_ready,
  output ex_mem_ctrl_t          out_ctrl,
  output logic [DATA_W-1:0]     out_alu,
  output logic [DATA_W-1:0]     out_rd3,
  output logic [REG_ADDR_W-1:0] out_rr3,
`ifdef EX_MEM_FWD_EN
  input  logic [REG_ADDR_W-1:0] fwd_rs_a,
  input  logic [REG_ADDR_W-1:0] fwd_rs_b,
  output logic                  fwd_hit_a,
  output logic                  fwd_hit_b,
  output logic [DATA_W-1:0]     fwd_data,
`endif
  output logic [1:0]            occupancy
);

  typedef struct packed {
    ex_mem_ctrl_t          ctrl;
    logic [DATA_W-1:0]     alu;
    logic [DATA_W-1:0]     rd3;
    logic [REG_ADDR_W-1:0] rr3;
  } slot_t;

  // flush clears ctrl, data fields hold
  localparam slot_t KEEP = '{
    ctrl: '0, alu: '1, rd3: '1, rr3: '1
  };

  slot_t in_d;
  slot_t out_d;
  logic  skid_valid;

  assign in_d = '{
    ctrl: in_ctrl, alu: in_alu,
    rd3: in_rd3, rr3: in_rr3
  };

  pipe_skid_buf #(
    .T         (slot_t),
    .KEEP_MASK (KEEP)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_d),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_d),
    .skid_valid (skid_valid)
  );

  assign out_ctrl  = out_valid ? out_d.ctrl : EX_MEM_CTRL_NOP;
  assign out_alu   = out_d.alu;
  assign out_rd3   = out_d.rd3;
  assign out_rr3   = out_d.rr3;
  assign occupancy = {1'b0, out_valid} + {1'b0, skid_valid};

`ifdef EX_MEM_FWD_EN
  logic fwd_ok;

  // loads are not forwardable from here; x0 never hits
  assign fwd_ok = out_valid & out_d.ctrl.reg_write
                & !out_d.ctrl.mem_read
                & (out_d.rr3 != '0);
  assign fwd_hit_a = fwd_ok & (out_d.rr3 == fwd_rs_a);
  assign fwd_hit_b = fwd_ok & (out_d.rr3 == fwd_rs_b);
  assign fwd_data  = out_d.alu;
`endif

endmodule

// File: tb/tb_ex_mem_stage_hs.sv
// Directed self-checking bench for ex_mem_stage_hs.
// Inputs driven/outputs sampled on posedge; DUT updates on negedge.
module tb_ex_mem_stage_hs;
  import pipe_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  ex_mem_ctrl_t in_ctrl;
  logic [31:0]  in_alu;
  logic [31:0]  in_rd3;
  logic [3:0]   in_rr3;
  logic         out_valid;
  logic         out_ready;
  ex_mem_ctrl_t out_ctrl;
  logic [31:0]  out_alu;
  logic [31:0]  out_rd3;
  logic [3:0]   out_rr3;
  logic [1:0]   occupancy;
`ifdef EX_MEM_FWD_EN
  logic [3:0]   fwd_rs_a;
  logic [3:0]   fwd_rs_b;
  logic         fwd_hit_a;
  logic         fwd_hit_b;
  logic [31:0]  fwd_data;
`endif

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  ex_mem_stage_hs #(.DATA_W(32), .REG_ADDR_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_alu    (in_alu),
    .in_rd3    (in_rd3),
    .in_rr3    (in_rr3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_alu   (out_alu),
    .out_rd3   (out_rd3),
    .out_rr3   (out_rr3),
`ifdef EX_MEM_FWD_EN
    .fwd_rs_a  (fwd_rs_a),
    .fwd_rs_b  (fwd_rs_b),
    .fwd_hit_a (fwd_hit_a),
    .fwd_hit_b (fwd_hit_b),
    .fwd_data  (fwd_data),
`endif
    .occupancy (occupancy)
  );

  task automatic tick;
    @(negedge clk);
    @(posedge clk);
  endtask

  task automatic drive(input logic v, input logic [3:0] c,
                       input logic [31:0] a, input logic [3:0] r);
    in_valid = v;
    in_ctrl  = c;
    in_alu   = a;
    in_rd3   = ~a;
    in_rr3   = r;
  endtask

  task automatic test_reset;
    out_ready = 1'b0;
    drive(1'b1, 4'b0001, 32'h7, 4'd1);
    tick();
    drive(1'b1, 4'b0001, 32'h8, 4'd2);
    tick();
    nvec++;
    if (occupancy !== 2'd2) begin
      nerr++;
      $display("FAIL pre_rst_occ got %0d want 2", occupancy);
    end
    #2 rst = 1'b1;
    #1;
    nvec++;
    if (out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL rst_valid got %b want 0", out_valid);
    end
    nvec++;
    if (out_ctrl !== 4'b0000) begin
      nerr++;
      $display("FAIL rst_ctrl got %b want 0000", out_ctrl);
    end
    nvec++;
    if (occupancy !== 2'd0) begin
      nerr++;
      $display("FAIL rst_occ got %0d want 0", occupancy);
    end
    drive(1'b0, 4'b0000, 32'h0, 4'd0);
    tick();
    rst = 1'b0;
    tick();
    nvec++;
    if (in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL rst_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_stream;
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 4'b0001, 32'(i), 4'(i));
      tick();
      nvec++;
      if (out_valid !== 1'b1 || out_alu !== 32'(i)) begin
        nerr++;
        $display("FAIL stream_%0d got v=%b alu=%0d want v=1 alu=%0d",
                 i, out_valid, out_alu, i);
      end
      nvec++;
      if (occupancy !== 2'd1) begin
        nerr++;
        $display("FAIL stream_occ_%0d got %0d want 1", i, occupancy);
      end
    end
    drive(1'b0, 4'b0000, 32'h0, 4'd0);
    tick();
    nvec++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      nerr++;
      $display("FAIL stream_drain got v=%b occ=%0d want v=0 occ=0",
               out_valid, occupancy);
    end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    drive(1'b1, 4'b0001, 32'hA, 4'd3);
    tick();
    nvec++;
    if (occupancy !== 2'd1 || out_alu !== 32'hA || in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL bp_first got occ=%0d alu=%h rdy=%b want 1 a 1",
               occupancy, out_alu, in_ready);
    end
    drive(1'b1, 4'b0001, 32'hB, 4'd4);
    tick();
    nvec++;
    if (occupancy !== 2'd2 || out_alu !== 32'hA || in_ready !== 1'b0) begin
      nerr++;
      $display("FAIL bp_full got occ=%0d alu=%h rdy=%b want 2 a 0",
               occupancy, out_alu, in_ready);
    end
    drive(1'b1, 4'b0001, 32'hC, 4'd5);
    tick();
    nvec++;
    if (occupancy !== 2'd2 || out_alu !== 32'hA) begin
      nerr++;
      $display("FAIL bp_hold got occ=%0d alu=%h want 2 a",
               occupancy, out_alu);
    end
    drive(1'b0, 4'b0000, 32'h0, 4'd0);
    out_ready = 1'b1;
    tick();
    nvec++;
    if (out_valid !== 1'b1 || out_alu !== 32'hB || out_rr3 !== 4'd4) begin
      nerr++;
      $display("FAIL bp_order got v=%b alu=%h rr3=%0d want 1 b 4",
               out_valid, out_alu, out_rr3);
    end
    nvec++;
    if (in_ready !== 1'b1 || occupancy !== 2'd1) begin
      nerr++;
      $display("FAIL bp_release got rdy=%b occ=%0d want 1 1",
               in_ready, occupancy);
    end
    tick();
    nvec++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      nerr++;
      $display("FAIL bp_empty got v=%b occ=%0d want 0 0",
               out_valid, occupancy);
    end
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    drive(1'b1, 4'b0011, 32'hD, 4'd6);
    tick();
    drive(1'b1, 4'b0011, 32'hE, 4'd7);
    tick();
    flush = 1'b1;
    drive(1'b1, 4'b0011, 32'hF, 4'd8);
    tick();
    nvec++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_ctrl !== 4'b0) begin
      nerr++;
      $display("FAIL flush got v=%b occ=%0d ctrl=%b want 0 0 0000",
               out_valid, occupancy, out_ctrl);
    end
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 4'b0000, 32'h0, 4'd0);
    tick();
    nvec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL flush_drop got v=%b rdy=%b want 0 1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_bubble;
    out_ready = 1'b1;
    drive(1'b1, 4'b0010, 32'h11, 4'd2);
    tick();
    nvec++;
    if (out_ctrl !== 4'b0010) begin
      nerr++;
      $display("FAIL bubble_valid got %b want 0010", out_ctrl);
    end
    drive(1'b0, 4'b0010, 32'h12, 4'd2);
    tick();
    nvec++;
    if (out_valid !== 1'b0 || out_ctrl !== 4'b0000) begin
      nerr++;
      $display("FAIL bubble_mask got v=%b ctrl=%b want 0 0000",
               out_valid, out_ctrl);
    end
  endtask

`ifdef EX_MEM_FWD_EN
  task automatic test_fwd;
    out_ready = 1'b0;
    fwd_rs_a = 4'd5;
    fwd_rs_b = 4'd3;
    drive(1'b1, 4'b0001, 32'h55, 4'd5);
    tick();
    nvec++;
    if (fwd_hit_a !== 1'b1 || fwd_hit_b !== 1'b0 || fwd_data !== 32'h55) begin
      nerr++;
      $display("FAIL fwd_hit got a=%b b=%b d=%h want 1 0 55",
               fwd_hit_a, fwd_hit_b, fwd_data);
    end
    out_ready = 1'b1;
    drive(1'b1, 4'b0101, 32'h66, 4'd5);
    tick();
    nvec++;
    if (out_valid !== 1'b1 || fwd_hit_a !== 1'b0) begin
      nerr++;
      $display("FAIL fwd_load got v=%b a=%b want 1 0",
               out_valid, fwd_hit_a);
    end
    fwd_rs_a = 4'd0;
    drive(1'b1, 4'b0001, 32'h77, 4'd0);
    tick();
    nvec++;
    if (out_valid !== 1'b1 || fwd_hit_a !== 1'b0) begin
      nerr++;
      $display("FAIL fwd_x0 got v=%b a=%b want 1 0",
               out_valid, fwd_hit_a);
    end
    drive(1'b0, 4'b0000, 32'h0, 4'd0);
    tick();
  endtask
`endif

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 4'b0000, 32'h0, 4'd0);
`ifdef EX_MEM_FWD_EN
    fwd_rs_a = 4'd0;
    fwd_rs_b = 4'd0;
`endif
    tick();
    rst = 1'b0;
    tick();
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_bubble();
`ifdef EX_MEM_FWD_EN
    test_fwd();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
